// File: rtl/add_serial_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : add_serial_ctrl_if
// Description : Operand, adder and result signal bundle for add_serial_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface add_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_en;
    logic [WIDTH-1:0] add_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [7:0]       done_cnt;

    modport master (
        output op_valid, op_a, op_b, add_out, res_ready,
        input  op_ready, add_a, add_b, add_en, res_valid, res_data, done_cnt
    );

    modport slave (
        input  op_valid, op_a, op_b, add_out, res_ready,
        output op_ready, add_a, add_b, add_en, res_valid, res_data, done_cnt
    );
endinterface
`default_nettype wire

// File: rtl/add_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : add_serial_ctrl
// Description : Sequencer/collector around the bit-serial adder add_serial.
// Revision    : 1.0 - initial release
// ============================================================================
module add_serial_ctrl #(
    parameter int   WIDTH         = 8,
    parameter int   RUN_CYCLES    = 10,
    parameter logic ADD_EN_ACTIVE = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    add_serial_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] c_WAIT_LAST = 8'(RUN_CYCLES - 1);

    state_t           r_state;
    logic [7:0]       r_wait_cnt;
    logic [WIDTH-1:0] r_add_a;
    logic [WIDTH-1:0] r_add_b;
    logic             r_add_en;
    logic             r_op_ready;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_valid;
    logic [7:0]       r_done_cnt;

    logic w_accept;
    logic w_capture;

    assign w_accept  = r_op_ready && bus.op_valid;
    // Capture only once the adder is final and the result slot is free or being drained.
    assign w_capture = (r_state == S_WAIT) && (r_wait_cnt == c_WAIT_LAST) &&
                       (!r_res_valid || bus.res_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 8'd0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_en    <= ~ADD_EN_ACTIVE;
            r_op_ready  <= 1'b1;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_done_cnt  <= 8'd0;
        end else begin
            if (w_capture) begin
                r_res_data  <= bus.add_out;
                r_res_valid <= 1'b1;
                r_done_cnt  <= r_done_cnt + 8'd1;
            end else if (r_res_valid && bus.res_ready) begin
                r_res_valid <= 1'b0;
            end

            // add_en is registered alongside the next state so it decodes S_START/S_RELEASE only.
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_add_a    <= bus.op_a;
                        r_add_b    <= bus.op_b;
                        r_op_ready <= 1'b0;
                        r_add_en   <= ADD_EN_ACTIVE;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_wait_cnt <= 8'd0;
                    r_add_en   <= ~ADD_EN_ACTIVE;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_capture) begin
                        r_add_en <= ADD_EN_ACTIVE;
                        r_state  <= S_RELEASE;
                    end else if (r_wait_cnt != c_WAIT_LAST) begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_RELEASE: begin
                    r_add_en   <= ~ADD_EN_ACTIVE;
                    r_op_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_add_en   <= ~ADD_EN_ACTIVE;
                    r_op_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.op_ready  = r_op_ready;
    assign bus.add_a     = r_add_a;
    assign bus.add_b     = r_add_b;
    assign bus.add_en    = r_add_en;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.done_cnt  = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_add_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_serial_ctrl
// Description : Self-checking bench for add_serial_ctrl with a behavioural adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_serial_ctrl;

    localparam int   WIDTH      = 8;
    localparam int   RUN_CYCLES = 10;
    localparam logic ACT        = 1'b0;
    localparam logic INACT      = ~ACT;
    localparam int   OP_PERIOD  = RUN_CYCLES + 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_done = 8'd0;

    always #5 clk = ~clk;

    add_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

    add_serial_ctrl #(
        .WIDTH         (WIDTH),
        .RUN_CYCLES    (RUN_CYCLES),
        .ADD_EN_ACTIVE (ACT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural adder: garbage while running, sum final RUN_CYCLES edges after the start sample.
    int ad_st  = 0;
    int ad_cnt = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ad_st       <= 0;
            ad_cnt      <= 0;
            bus.add_out <= '0;
        end else begin
            case (ad_st)
                0: if (bus.add_en == ACT) begin
                    ad_st       <= 1;
                    ad_cnt      <= 1;
                    bus.add_out <= 8'($urandom);
                end
                1: if (ad_cnt == RUN_CYCLES - 1) begin
                    ad_st       <= 2;
                    bus.add_out <= 8'(bus.add_a + bus.add_b);
                end else begin
                    ad_cnt      <= ad_cnt + 1;
                    bus.add_out <= 8'($urandom);
                end
                default: if (bus.add_en == ACT) ad_st <= 0;
            endcase
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an operand pair and returns once the accept edge has passed.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, output bit ok);
        logic rdy;
        ok = 1'b0;
        bus.op_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        for (int i = 0; i < 60 && !ok; i++) begin
            rdy = bus.op_ready;
            tick();
            if (rdy) ok = 1'b1;
        end
        bus.op_valid = 1'b0;
    endtask

    task automatic wait_result(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (bus.res_valid) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready: got %b expected 1", bus.op_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
        checks++; if (bus.add_en !== INACT) begin errors++; $display("FAIL reset_add_en: got %b expected %b", bus.add_en, INACT); end
        checks++; if (bus.done_cnt !== 8'd0) begin errors++; $display("FAIL reset_done_cnt: got %h expected 00", bus.done_cnt); end
        checks++; if (bus.add_a !== 8'd0 || bus.add_b !== 8'd0) begin errors++; $display("FAIL reset_add_ab: got %h/%h expected 00/00", bus.add_a, bus.add_b); end
        checks++; if (bus.res_data !== 8'd0) begin errors++; $display("FAIL reset_res_data: got %h expected 00", bus.res_data); end
        tick();
        #3 rst = 1'b0;
        exp_done = 8'd0;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        logic [7:0] a, b, s;
        logic exp_en, exp_rv, exp_rdy;
        a = 8'h3C; b = 8'h15; s = 8'(a + b);
        bus.res_ready = 1'b0;
        issue(a, b, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_accept: got timeout expected accept"); end
        checks++; if (bus.add_en !== ACT) begin errors++; $display("FAIL single_start_en: got %b expected %b", bus.add_en, ACT); end
        checks++; if (bus.add_a !== a || bus.add_b !== b) begin errors++; $display("FAIL single_add_ab: got %h/%h expected %h/%h", bus.add_a, bus.add_b, a, b); end
        for (int k = 1; k <= RUN_CYCLES + 2; k++) begin
            tick();
            exp_en  = (k == RUN_CYCLES + 1) ? ACT : INACT;
            exp_rv  = (k >= RUN_CYCLES + 1);
            exp_rdy = (k >= RUN_CYCLES + 2);
            checks++; if (bus.add_en !== exp_en) begin errors++; $display("FAIL single_add_en E%0d: got %b expected %b", k, bus.add_en, exp_en); end
            checks++; if (bus.res_valid !== exp_rv) begin errors++; $display("FAIL single_res_valid E%0d: got %b expected %b", k, bus.res_valid, exp_rv); end
            checks++; if (bus.op_ready !== exp_rdy) begin errors++; $display("FAIL single_op_ready E%0d: got %b expected %b", k, bus.op_ready, exp_rdy); end
        end
        exp_done = exp_done + 8'd1;
        checks++; if (bus.res_data !== s) begin errors++; $display("FAIL single_res_data: got %h expected %h", bus.res_data, s); end
        checks++; if (bus.done_cnt !== exp_done) begin errors++; $display("FAIL single_done_cnt: got %h expected %h", bus.done_cnt, exp_done); end
        bus.res_ready = 1'b1;
        tick();
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_consume: got %b expected 0", bus.res_valid); end
        bus.res_ready = 1'b0;
    endtask

    task automatic test_wrap();
        bit ok;
        logic [7:0] s;
        s = 8'(9'h0FF + 9'h002);
        issue(8'hFF, 8'h02, ok);
        wait_result(ok);
        exp_done = exp_done + 8'd1;
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: got no result expected res_valid"); end
        checks++; if (bus.res_data !== s) begin errors++; $display("FAIL wrap_res_data: got %h expected %h", bus.res_data, s); end
        checks++; if (bus.done_cnt !== exp_done) begin errors++; $display("FAIL wrap_done_cnt: got %h expected %h", bus.done_cnt, exp_done); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        int acc_cyc[$];
        int n_acc, n_done, cyc;
        logic acc, con;
        logic [7:0] d, dc, e;
        n_acc = 0; n_done = 0; cyc = 0;
        bus.res_ready = 1'b1;
        bus.op_valid  = 1'b1;
        bus.op_a = 8'($urandom); bus.op_b = 8'($urandom);
        while (n_done < 5 && cyc < 200) begin
            acc = bus.op_valid && bus.op_ready;
            con = bus.res_valid && bus.res_ready;
            d = bus.res_data; dc = bus.done_cnt;
            tick();
            cyc++;
            if (con) begin
                exp_done = exp_done + 8'd1;
                e = (q.size() > 0) ? q.pop_front() : ~d;
                checks++; if (d !== e) begin errors++; $display("FAIL b2b_res_data #%0d: got %h expected %h", n_done, d, e); end
                checks++; if (dc !== exp_done) begin errors++; $display("FAIL b2b_done_cnt #%0d: got %h expected %h", n_done, dc, exp_done); end
                n_done++;
            end
            if (acc) begin
                q.push_back(8'(bus.op_a + bus.op_b));
                acc_cyc.push_back(cyc);
                n_acc++;
                if (n_acc < 5) begin
                    bus.op_a = 8'($urandom); bus.op_b = 8'($urandom);
                end else begin
                    bus.op_valid = 1'b0;
                end
            end
        end
        checks++; if (n_done != 5) begin errors++; $display("FAIL b2b_timeout: got %0d results expected 5", n_done); end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++; if (acc_cyc[i] - acc_cyc[i-1] != OP_PERIOD) begin errors++; $display("FAIL b2b_spacing #%0d: got %0d expected %0d", i, acc_cyc[i] - acc_cyc[i-1], OP_PERIOD); end
        end
        bus.op_valid  = 1'b0;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [7:0] s1, s2;
        s1 = 8'(8'h3C + 8'h15);
        s2 = 8'(8'h10 + 8'h20);
        bus.res_ready = 1'b0;
        issue(8'h3C, 8'h15, ok);
        wait_result(ok);
        exp_done = exp_done + 8'd1;
        issue(8'h10, 8'h20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_accept: got timeout expected accept"); end
        for (int k = 1; k <= RUN_CYCLES + 4; k++) begin
            tick();
            checks++; if (bus.res_data !== s1 || bus.res_valid !== 1'b1) begin errors++; $display("FAIL bp_hold E%0d: got %h/%b expected %h/1", k, bus.res_data, bus.res_valid, s1); end
            checks++; if (bus.add_en !== INACT || bus.op_ready !== 1'b0) begin errors++; $display("FAIL bp_stall E%0d: got en=%b rdy=%b expected en=%b rdy=0", k, bus.add_en, bus.op_ready, INACT); end
        end
        bus.res_ready = 1'b1;
        tick();
        exp_done = exp_done + 8'd1;
        bus.res_ready = 1'b0;
        checks++; if (bus.res_data !== s2 || bus.res_valid !== 1'b1) begin errors++; $display("FAIL bp_capture: got %h/%b expected %h/1", bus.res_data, bus.res_valid, s2); end
        checks++; if (bus.done_cnt !== exp_done) begin errors++; $display("FAIL bp_done_cnt: got %h expected %h", bus.done_cnt, exp_done); end
        checks++; if (bus.add_en !== ACT) begin errors++; $display("FAIL bp_release: got %b expected %b", bus.add_en, ACT); end
        tick();
        bus.res_ready = 1'b1;
        tick();
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL bp_consume: got %b expected 0", bus.res_valid); end
        bus.res_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [7:0] a, b, s2;
        bus.res_ready = 1'b0;
        issue(8'($urandom), 8'($urandom), ok);
        wait_result(ok);
        exp_done = exp_done + 8'd1;
        a = 8'($urandom); b = 8'($urandom); s2 = 8'(a + b);
        issue(a, b, ok);
        for (int k = 1; k <= RUN_CYCLES; k++) begin
            tick();
            checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL sim_valid E%0d: got %b expected 1", k, bus.res_valid); end
        end
        bus.res_ready = 1'b1;
        tick();
        exp_done = exp_done + 8'd1;
        bus.res_ready = 1'b0;
        checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== s2) begin errors++; $display("FAIL sim_capture: got %h/%b expected %h/1", bus.res_data, bus.res_valid, s2); end
        checks++; if (bus.done_cnt !== exp_done) begin errors++; $display("FAIL sim_done_cnt: got %h expected %h", bus.done_cnt, exp_done); end
        tick();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] a, b;
        bus.res_ready = 1'b0;
        issue(8'($urandom), 8'($urandom), ok);
        wait_result(ok);
        issue(8'($urandom), 8'($urandom), ok);
        for (int k = 1; k <= 5; k++) tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.op_ready !== 1'b1 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL rmid_handshake: got rdy=%b rv=%b expected rdy=1 rv=0", bus.op_ready, bus.res_valid); end
        checks++; if (bus.add_en !== INACT || bus.done_cnt !== 8'd0) begin errors++; $display("FAIL rmid_en_cnt: got en=%b cnt=%h expected en=%b cnt=00", bus.add_en, bus.done_cnt, INACT); end
        tick();
        #3 rst = 1'b0;
        exp_done = 8'd0;
        tick();
        a = 8'($urandom); b = 8'($urandom);
        issue(a, b, ok);
        wait_result(ok);
        exp_done = exp_done + 8'd1;
        checks++; if (bus.res_data !== 8'(a + b)) begin errors++; $display("FAIL rmid_sum: got %h expected %h", bus.res_data, 8'(a + b)); end
        checks++; if (bus.done_cnt !== exp_done) begin errors++; $display("FAIL rmid_done_cnt: got %h expected %h", bus.done_cnt, exp_done); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_done_wrap();
        logic [7:0] q[$];
        int n_done, cyc;
        logic acc, con;
        logic [7:0] d, dc, e, start_cnt;
        n_done = 0; cyc = 0;
        start_cnt = exp_done;
        bus.res_ready = 1'b1;
        bus.op_valid  = 1'b1;
        bus.op_a = 8'($urandom); bus.op_b = 8'($urandom);
        while (n_done < 256 && cyc < 256 * OP_PERIOD + 100) begin
            acc = bus.op_valid && bus.op_ready;
            con = bus.res_valid && bus.res_ready;
            d = bus.res_data; dc = bus.done_cnt;
            tick();
            cyc++;
            if (con) begin
                exp_done = exp_done + 8'd1;
                e = (q.size() > 0) ? q.pop_front() : ~d;
                checks++; if (d !== e || dc !== exp_done) begin errors++; $display("FAIL wrapcnt #%0d: got %h cnt=%h expected %h cnt=%h", n_done, d, dc, e, exp_done); end
                n_done++;
                if (n_done == 256) bus.op_valid = 1'b0;
            end
            if (acc) begin
                q.push_back(8'(bus.op_a + bus.op_b));
                bus.op_a = 8'($urandom); bus.op_b = 8'($urandom);
            end
        end
        bus.op_valid  = 1'b0;
        bus.res_ready = 1'b0;
        checks++; if (n_done != 256) begin errors++; $display("FAIL wrapcnt_timeout: got %0d results expected 256", n_done); end
        checks++; if (bus.done_cnt !== start_cnt) begin errors++; $display("FAIL wrapcnt_final: got %h expected %h", bus.done_cnt, start_cnt); end
    endtask

    initial begin
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_done_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/add_serial_ctrl.md
Name: add_serial_ctrl

Overview:
- Upstream sequencer and downstream collector for the 8-bit bit-serial adder (add_serial).
- Accepts operand pairs on a valid/ready interface and holds them stable on the adder's a/b inputs.
- Drives the adder's start/acknowledge enable and waits the adder's fixed run time.
- Captures the adder's out into a result register, offered on a valid/ready interface with backpressure.

Parameters:
WIDTH, 8, operand/result width; must match the adder width.
RUN_CYCLES, 10, clock edges from the adder sampling a start enable until its out is final; legal range 2..255.
ADD_EN_ACTIVE, 1'b0, level on add_en that the adder treats as "enable"; the inactive level is ~ADD_EN_ACTIVE.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
op_valid  input  1  operand pair valid
op_ready  output  1  block can accept an operand pair
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
add_a  output  WIDTH  registered operand A to adder
add_b  output  WIDTH  registered operand B to adder
add_en  output  1  adder enable, ADD_EN_ACTIVE polarity
add_out  input  WIDTH  adder result
res_valid  output  1  result register holds unconsumed data
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  captured result
done_cnt  output  8  count of captured results, wraps modulo 256

Behaviour:
Reset values:
- state = S_IDLE; add_a, add_b, res_data, done_cnt, wait counter = 0; res_valid = 0.
- add_en = ~ADD_EN_ACTIVE; op_ready = 1.

States:
- S_IDLE: op_ready = 1. On op_valid & op_ready, latch op_a/op_b into add_a/add_b and go to S_START.
- S_START: add_en = ADD_EN_ACTIVE for exactly this one cycle. Wait counter is cleared. Next state is S_WAIT.
- S_WAIT: add_en inactive; counter increments each cycle, saturating at RUN_CYCLES-1.
  - When counter == RUN_CYCLES-1 and (!res_valid | res_ready): capture add_out into res_data, set res_valid, increment done_cnt, go to S_RELEASE.
  - Otherwise stay in S_WAIT. The adder idles in its DONE state with out stable.
- S_RELEASE: add_en = ADD_EN_ACTIVE for exactly one cycle, which returns the adder from DONE to IDLE. Next state is S_IDLE.

Timing and handshake rules:
- add_en is decoded from state only (active iff S_START or S_RELEASE), so it is glitch-free relative to the clock and inactive during and immediately after reset.
- op_ready is 0 in every state except S_IDLE. add_a/add_b are constant from the accept edge until the next accept.
- Timing from the accept edge E0:
  - Adder samples start at E1.
  - Capture at E1+RUN_CYCLES (E11 by default); res_valid is high from that edge.
  - Release at E12; op_ready high after E12.
  - Sustained throughput: one operation per RUN_CYCLES+3 cycles (13 by default).
- res_valid clears on an edge with res_valid & res_ready, unless a capture occurs on the same edge. In that case res_data takes the new value and res_valid stays 1.
- res_data holds its value while res_valid & !res_ready.
- No arithmetic is performed here; res_data is add_out verbatim (WIDTH bits, no carry-out).
- done_cnt wraps from 255 to 0.
- op_valid while op_ready = 0 is ignored (not latched). The source must hold op_valid/op_a/op_b until accepted.
- Reset mid-operation returns to S_IDLE immediately, drops any pending result (res_valid = 0), and drives add_en inactive. The adder shares rst and returns to its IDLE, so no release cycle is needed.

Test Plan:
- Reset (ADD_EN_ACTIVE=0): assert rst mid-cycle -> op_ready=1, res_valid=0, add_en=1, done_cnt=0, add_a=add_b=0 without a clock edge.
- Single op with behavioural adder: op_a=8'h3C, op_b=8'h15 accepted at E0 -> add_en=0 only in cycle E0..E1; res_valid rises at E11 with res_data=8'h51; add_en=0 again E11..E12; op_ready=1 after E12; done_cnt=1.
- Wrap sum: op_a=8'hFF, op_b=8'h02 -> res_data=8'h01. Back-to-back ops with op_valid held -> accepts exactly 13 cycles apart.
- Backpressure: res_ready=0, first result 8'h51 pending, second op 8'h10+8'h20 -> block stays in S_WAIT past E11, add_en inactive, res_data=8'h51. Raise res_ready -> next edge res_data=8'h30, res_valid stays 1, done_cnt=2.
- Simultaneous consume/capture: res_ready=1 on the capture edge with the old result pending -> res_data replaced, res_valid stays 1, no cycle where res_valid=0.
- Reset at E5 of an op -> state S_IDLE, res_valid=0, add_en=1. A new op afterwards gives a correct sum. 256 ops -> done_cnt returns to 0.
